// File: rtl/mvm_pkg.sv
// Shared types and saturating arithmetic for the matrix-vector engine.
// Holds the FSM state encoding and the per-layer weight tables.
package mvm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    function automatic logic signed [63:0] sat_max(input int t);
        return (64'sd1 <<< (t - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int t);
        return -(64'sd1 <<< (t - 1));
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v, input int t);
        if (v > sat_max(t)) return sat_max(t);
        if (v < sat_min(t)) return sat_min(t);
        return v;
    endfunction

    // Operands are t-bit values sign-extended to 32 bits; result fits in t bits.
    function automatic logic signed [31:0] sat_mul(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int t);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return 32'(clamp(p, t));
    endfunction

    // A same-sign overflow always pushes the wide sum past max/min, so clamping it
    // saturates toward the sign of the accumulator.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int t);
        logic signed [63:0] s;
        s = 64'(a) + 64'(b);
        return 32'(clamp(s, t));
    endfunction

    // Layer 0 is the built-in test table; layers 1-3 are rewritten by the network generator.
    function automatic int layer_weight(input int l, input int row, input int col);
        if (l == 0) return row + 1;
        return ((row * 7 + col * 3 + l * 5) % 9) - 4;
    endfunction

endpackage

// File: rtl/mvm_lane.sv
// One MAC lane: weight ROM, registered saturating product, saturating accumulator.
// Latency: ROM 1 cycle, product 1 cycle, accumulate 1 cycle; no backpressure (driven by engine).
// Holds rows LANE, LANE+P, ... at ROM address g*N+j.
module mvm_lane
    import mvm_pkg::*;
#(
    parameter int T     = 8,
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int P     = 2,
    parameter int L     = 1,
    parameter int LANE  = 0,
    localparam int DEPTH = M * N / P,
    localparam int RAW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                acc_en_i,
    input  logic [RAW-1:0]      rom_addr_i,
    input  logic signed [T-1:0] x_i,
    output logic signed [T-1:0] acc_o
);

    logic signed [T-1:0] rom [DEPTH];
    logic signed [T-1:0] w_q;
    logic signed [T-1:0] prod_q;
    logic signed [T-1:0] acc_q;

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = T'(layer_weight(L, (a / N) * P + LANE, a % N));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q    <= '0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            w_q    <= rom[rom_addr_i];
            prod_q <= T'(sat_mul(32'(x_i), 32'(w_q), T));
            if (clr_i)
                acc_q <= '0;
            else if (acc_en_i)
                acc_q <= T'(sat_add(32'(acc_q), 32'(prod_q), T));
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mvm_pipe_engine.sv
// Streams an N-vector in, multiplies by an MxN ROM matrix on P saturating lanes, streams M rows out.
// Latency: first row of each group N+3 cycles after its trigger beat; RELU_EN clamps outputs at 0.
// Backpressure: s_ready only in LOAD; m_data/m_valid held while m_ready is low.
module mvm_pipe_engine
    import mvm_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8,
    parameter int T = 8,
    parameter int P = 2,
    parameter int L = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic signed [T-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic signed [T-1:0] m_data,
    output logic                done
);

    localparam int G     = M / P;
    localparam int XW    = $clog2(N);
    localparam int CW    = $clog2(N + 2);
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int BW    = (P > 1) ? $clog2(P) : 1;
    localparam int DEPTH = M * N / P;
    localparam int RAW   = $clog2(DEPTH);

    state_t              state_q, state_d;
    logic [XW-1:0]       addr_x_q, addr_x_d;
    logic [CW-1:0]       col_q, col_d;
    logic [GW-1:0]       g_q, g_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                m_valid_q, m_valid_d;
    logic signed [T-1:0] m_data_q, m_data_d;
    logic                v1_q, v2_q;
    logic signed [T-1:0] x_rd_q;
    logic signed [T-1:0] xmem_q [N];

    logic                issue;
    logic                acc_clr;
    logic                s_fire;
    logic [XW-1:0]       x_addr;
    logic [RAW-1:0]      rom_addr;
    logic signed [T-1:0] lane_acc [P];

    function automatic logic signed [T-1:0] out_val(input logic signed [T-1:0] v);
`ifdef RELU_EN
        return v[T-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign s_ready  = (state_q == ST_LOAD);
    assign s_fire   = s_valid && s_ready;
    assign issue    = (state_q == ST_COMPUTE) && (col_q < CW'(N));
    assign x_addr   = issue ? col_q[XW-1:0] : '0;
    assign rom_addr = issue ? RAW'(int'(g_q) * N + int'(col_q)) : '0;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign done     = (state_q == ST_OUTPUT) && m_valid_q && m_ready &&
                      (beat_q == BW'(P - 1)) && (g_q == GW'(G - 1));

    always_comb begin
        state_d   = state_q;
        addr_x_d  = addr_x_q;
        col_d     = col_q;
        g_d       = g_q;
        beat_d    = beat_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        acc_clr   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (s_fire) begin
                    if (addr_x_q == XW'(N - 1)) begin
                        addr_x_d = '0;
                        g_d      = '0;
                        col_d    = '0;
                        acc_clr  = 1'b1;
                        state_d  = ST_COMPUTE;
                    end else begin
                        addr_x_d = addr_x_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                // N issue cycles followed by two drain cycles.
                if (col_q == CW'(N + 1)) begin
                    col_d   = '0;
                    beat_d  = '0;
                    state_d = ST_OUTPUT;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            ST_OUTPUT: begin
                // First OUTPUT cycle registers lane 0; the final accumulate lands on entry.
                if (!m_valid_q) begin
                    m_valid_d = 1'b1;
                    m_data_d  = out_val(lane_acc[beat_q]);
                end else if (m_ready) begin
                    if (beat_q == BW'(P - 1)) begin
                        m_valid_d = 1'b0;
                        beat_d    = '0;
                        if (g_q == GW'(G - 1)) begin
                            g_d     = '0;
                            state_d = ST_LOAD;
                        end else begin
                            g_d     = g_q + 1'b1;
                            col_d   = '0;
                            acc_clr = 1'b1;
                            state_d = ST_COMPUTE;
                        end
                    end else begin
                        beat_d   = beat_q + 1'b1;
                        m_data_d = out_val(lane_acc[BW'(beat_q + 1'b1)]);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            addr_x_q  <= '0;
            col_q     <= '0;
            g_q       <= '0;
            beat_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            x_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_x_q  <= addr_x_d;
            col_q     <= col_d;
            g_q       <= g_d;
            beat_q    <= beat_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            v1_q      <= issue;
            v2_q      <= v1_q;
            x_rd_q    <= xmem_q[x_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && s_fire)
            xmem_q[addr_x_q] <= s_data;
    end

    for (genvar i = 0; i < P; i++) begin : g_lane
        mvm_lane #(
            .T    (T),
            .N    (N),
            .M    (M),
            .P    (P),
            .L    (L),
            .LANE (i)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .clr_i      (acc_clr),
            .acc_en_i   (v2_q),
            .rom_addr_i (rom_addr),
            .x_i        (x_rd_q),
            .acc_o      (lane_acc[i])
        );
    end

endmodule

// File: tb/tb_mvm_pipe_engine.sv
// Self-checking bench for mvm_pipe_engine (T=8, M=4, N=4, P=2, L=0): directed and random vectors
// checked against an arithmetic model of the saturating matrix-vector product.
module tb_mvm_pipe_engine;

    localparam int M    = 4;
    localparam int N    = 4;
    localparam int T    = 8;
    localparam int P    = 2;
    localparam int MAXV = (1 << (T - 1)) - 1;
    localparam int MINV = -(1 << (T - 1));

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [T-1:0] s_data = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic signed [T-1:0] m_data;
    logic                done;

    int tests = 0;
    int fails = 0;
    int xv [N];

    mvm_pipe_engine #(.M(M), .N(N), .T(T), .P(P), .L(0)) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic int clampv(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Row r of the test ROM has every weight equal to r+1.
    function automatic int model_row(input int r);
        int acc;
        acc = 0;
        for (int j = 0; j < N; j++)
            acc = clampv(acc + clampv(xv[j] * (r + 1)));
`ifdef RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vector();
        for (int j = 0; j < N; j++) begin
            s_valid = 1'b1;
            s_data  = T'(xv[j]);
            step();
        end
        s_valid = 1'b0;
    endtask

    // stall < 0 picks a random stall per row; junk drives s_valid=1/s_data=99 while busy.
    task automatic run_vector(input int stall, input bit junk);
        int cyc;
        int st;
        int exp_v;
        logic signed [T-1:0] held;
        load_vector();
        s_valid = junk;
        s_data  = junk ? T'(99) : '0;
        for (int r = 0; r < M; r++) begin
            cyc = 0;
            while (!m_valid && cyc < 100) begin
                step();
                cyc++;
            end
            tests++;
            if (cyc != ((r % P == 0) ? N + 3 : 0)) begin
                fails++;
                $display("FAIL latency row %0d: got %0d cycles, expected %0d", r, cyc,
                         (r % P == 0) ? N + 3 : 0);
            end
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            held = m_data;
            for (int k = 0; k < st; k++) begin
                step();
                tests++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    fails++;
                    $display("FAIL hold row %0d: m_valid=%b m_data=%0d, expected 1 and %0d",
                             r, m_valid, $signed(m_data), $signed(held));
                end
            end
            exp_v = model_row(r);
            tests++;
            if (m_data !== T'(exp_v)) begin
                fails++;
                $display("FAIL row %0d data: got %0d, expected %0d", r, $signed(m_data), exp_v);
            end
            m_ready = 1'b1;
            #1;
            tests++;
            if (done !== (r == M - 1)) begin
                fails++;
                $display("FAIL done row %0d: got %b, expected %b", r, done, (r == M - 1));
            end
            if (junk) begin
                tests++;
                if (s_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL s_ready busy row %0d: got %b, expected 0", r, s_ready);
                end
            end
            step();
            m_ready = 1'b0;
        end
        s_valid = 1'b0;
        s_data  = '0;
        tests++;
        if (done !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL post-vector: done=%b m_valid=%b s_ready=%b, expected 0 0 1",
                     done, m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if (m_valid !== 1'b0 || m_data !== '0 || done !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset state: m_valid=%b m_data=%0d done=%b s_ready=%b, expected 0 0 0 1",
                     m_valid, $signed(m_data), done, s_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        xv = '{1, 2, 3, 4};
        run_vector(0, 1'b0);
    endtask

    task automatic test_saturation();
        xv = '{100, 100, 100, 100};
        run_vector(0, 1'b0);
        xv = '{-50, -50, -50, -50};
        run_vector(0, 1'b0);
    endtask

    task automatic test_backpressure();
        xv = '{1, 2, 3, 4};
        run_vector(5, 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        xv = '{1, 2, 3, 4};
        load_vector();
        cyc = 0;
        while (!m_valid && cyc < 100) begin
            step();
            cyc++;
        end
        m_ready = 1'b1;
        step();
        step();
        m_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset mid-compute: m_valid=%b s_ready=%b, expected 0 1", m_valid, s_ready);
        end
        reset = 1'b0;
        step();
        xv = '{1, 1, 1, 1};
        run_vector(0, 1'b0);
    endtask

    task automatic test_ignore_input();
        xv = '{1, 2, 3, 4};
        run_vector(1, 1'b1);
    endtask

    task automatic test_random();
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < N; j++)
                xv[j] = int'($urandom_range(0, 255)) - 128;
            run_vector(-1, v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_ignore_input();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
